// File: rtl/vga_timing_if.sv
// Raster timing bundle passed from the timing generator to the drawing stages.
// The `out` modport belongs to the timing source, `in` to every consumer.
interface vga_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );

  modport in (
    input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator (800x600 @ 60 Hz by default).
// Counters and strobes are registered together so they stay cycle-aligned.
module vga_timing #(
  parameter int HOR_TOTAL_TIME  = 1056,
  parameter int HOR_BLANK_START = 800,
  parameter int HOR_SYNC_START  = 840,
  parameter int HOR_SYNC_TIME   = 128,
  parameter int VER_TOTAL_TIME  = 628,
  parameter int VER_BLANK_START = 600,
  parameter int VER_SYNC_START  = 601,
  parameter int VER_SYNC_TIME   = 4
) (
  input  logic clk,
  input  logic rst,
  vga_if.out   vga_out
);

  localparam logic [10:0] H_LAST     = 11'(HOR_TOTAL_TIME - 1);
  localparam logic [10:0] H_BLANK    = 11'(HOR_BLANK_START);
  localparam logic [10:0] H_SYNC_BEG = 11'(HOR_SYNC_START);
  localparam logic [10:0] H_SYNC_END = 11'(HOR_SYNC_START + HOR_SYNC_TIME);
  localparam logic [10:0] V_LAST     = 11'(VER_TOTAL_TIME - 1);
  localparam logic [10:0] V_BLANK    = 11'(VER_BLANK_START);
  localparam logic [10:0] V_SYNC_BEG = 11'(VER_SYNC_START);
  localparam logic [10:0] V_SYNC_END = 11'(VER_SYNC_START + VER_SYNC_TIME);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;

  // Next counts, with strobes decoded from them so the registered strobes match the registered counts.
  always_comb begin
    hcount_d = 11'd0;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d = 11'd0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end else begin
      hcount_d = hcount_q + 11'd1;
    end

    hblnk_d = (hcount_d >= H_BLANK);
    hsync_d = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
    vblnk_d = (vcount_d >= V_BLANK);
    vsync_d = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
  end

  // Timing state; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      hblnk_q  <= hblnk_d;
      vsync_q  <= vsync_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = 12'h000;

endmodule

// File: tb/tb_vga_timing.sv
// Bench: a full-size SVGA instance checked over a few lines and a shrunken-mode
// instance checked over several whole frames against an arithmetic raster model.
`timescale 1ns/1ps
module tb_vga_timing;

  localparam int S_HT  = 40;
  localparam int S_HB  = 32;
  localparam int S_HSS = 34;
  localparam int S_HST = 4;
  localparam int S_VT  = 14;
  localparam int S_VB  = 9;
  localparam int S_VSS = 10;
  localparam int S_VST = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;
  int n      = 0;

  int s_hs_run, s_vs_run, s_last_vs_fall, f_hs_run, f_last_hs_rise;
  logic s_hs_prev, s_vs_prev, s_vb_prev, f_hs_prev;

  vga_if full_if ();
  vga_if small_if ();

  vga_timing u_full (
    .clk     (clk),
    .rst     (rst),
    .vga_out (full_if)
  );

  vga_timing #(
    .HOR_TOTAL_TIME  (S_HT),
    .HOR_BLANK_START (S_HB),
    .HOR_SYNC_START  (S_HSS),
    .HOR_SYNC_TIME   (S_HST),
    .VER_TOTAL_TIME  (S_VT),
    .VER_BLANK_START (S_VB),
    .VER_SYNC_START  (S_VSS),
    .VER_SYNC_TIME   (S_VST)
  ) u_small (
    .clk     (clk),
    .rst     (rst),
    .vga_out (small_if)
  );

  always #12.5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t n=%0d)", tag, act, exp, $time, n);
    end
  endtask

  // Raster position n pixel clocks after reset release, from plain division.
  task automatic check_mode(input string pfx, input int cyc,
                            input int ht, input int hb, input int hss, input int hst,
                            input int vt, input int vb, input int vss, input int vst,
                            input int oh, input int ov, input int ohs, input int ohb,
                            input int ovs, input int ovb, input int orgb);
    int h, v;
    h = cyc % ht;
    v = (cyc / ht) % vt;
    check_eq({pfx, "_hcount"}, oh, h);
    check_eq({pfx, "_vcount"}, ov, v);
    check_eq({pfx, "_hblnk"}, ohb, int'(h >= hb));
    check_eq({pfx, "_hsync"}, ohs, int'(h >= hss && h <= hss + hst - 1));
    check_eq({pfx, "_vblnk"}, ovb, int'(v >= vb));
    check_eq({pfx, "_vsync"}, ovs, int'(v >= vss && v <= vss + vst - 1));
    check_eq({pfx, "_rgb"}, orgb, 0);
  endtask

  task automatic check_both();
    check_mode("full", n, 1056, 800, 840, 128, 628, 600, 601, 4,
               int'(full_if.hcount), int'(full_if.vcount), int'(full_if.hsync),
               int'(full_if.hblnk), int'(full_if.vsync), int'(full_if.vblnk),
               int'(full_if.rgb));
    check_mode("small", n, S_HT, S_HB, S_HSS, S_HST, S_VT, S_VB, S_VSS, S_VST,
               int'(small_if.hcount), int'(small_if.vcount), int'(small_if.hsync),
               int'(small_if.hblnk), int'(small_if.vsync), int'(small_if.vblnk),
               int'(small_if.rgb));
  endtask

  task automatic clear_edges();
    s_hs_run = 0; s_vs_run = 0; s_last_vs_fall = -1;
    f_hs_run = 0; f_last_hs_rise = -1;
    s_hs_prev = 1'b0; s_vs_prev = 1'b0; s_vb_prev = 1'b0; f_hs_prev = 1'b0;
  endtask

  // Edge positions, pulse widths and periods seen on the outputs.
  task automatic check_edges();
    if (small_if.hsync && !s_hs_prev) check_eq("s_hsync_rise_h", int'(small_if.hcount), S_HSS);
    if (!small_if.hsync && s_hs_prev) check_eq("s_hsync_width", s_hs_run, S_HST);
    s_hs_run = small_if.hsync ? s_hs_run + 1 : 0;
    if (small_if.vsync && !s_vs_prev) begin
      check_eq("s_vsync_rise_h", int'(small_if.hcount), 0);
      check_eq("s_vsync_rise_v", int'(small_if.vcount), S_VSS);
    end
    if (!small_if.vsync && s_vs_prev) begin
      check_eq("s_vsync_width", s_vs_run, S_VST * S_HT);
      check_eq("s_vsync_fall_v", int'(small_if.vcount), S_VSS + S_VST);
      if (s_last_vs_fall >= 0) check_eq("s_vsync_period", n - s_last_vs_fall, S_HT * S_VT);
      s_last_vs_fall = n;
    end
    s_vs_run = small_if.vsync ? s_vs_run + 1 : 0;
    if (!small_if.vblnk && s_vb_prev) begin
      check_eq("s_vblnk_fall_h", int'(small_if.hcount), 0);
      check_eq("s_vblnk_fall_v", int'(small_if.vcount), 0);
      check_eq("s_hblnk_at_wrap", int'(small_if.hblnk), 0);
    end
    if (full_if.hsync && !f_hs_prev) begin
      if (f_last_hs_rise >= 0) check_eq("f_hsync_period", n - f_last_hs_rise, 1056);
      f_last_hs_rise = n;
    end
    if (!full_if.hsync && f_hs_prev) check_eq("f_hsync_width", f_hs_run, 128);
    f_hs_run = full_if.hsync ? f_hs_run + 1 : 0;
    s_hs_prev = small_if.hsync; s_vs_prev = small_if.vsync;
    s_vb_prev = small_if.vblnk; f_hs_prev = full_if.hsync;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) n = 0;
    else     n++;
    check_both();
    check_edges();
  endtask

  // Assert reset between edges, confirm zeros before the next edge, hold, release.
  task automatic pulse_reset(input int hold);
    #5;
    rst = 1'b1;
    #1;
    n = 0;
    clear_edges();
    check_both();
    for (int i = 0; i < hold; i++) tick();
    rst = 1'b0;
    tick();
    check_eq("post_release_full_h", int'(full_if.hcount), 1);
    check_eq("post_release_full_v", int'(full_if.vcount), 0);
    check_eq("post_release_small_h", int'(small_if.hcount), 1);
    check_eq("post_release_small_v", int'(small_if.vcount), 0);
  endtask

  initial begin
    clear_edges();
    @(posedge clk);
    #1;
    pulse_reset(2);
    for (int i = 0; i < 2300; i++) tick();
    for (int r = 0; r < 4; r++) begin
      int run_len;
      run_len = int'($urandom_range(150, 900));
      for (int i = 0; i < run_len; i++) tick();
      pulse_reset(int'($urandom_range(1, 4)));
    end
    for (int i = 0; i < 1200; i++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
